// File: rtl/gpio_bank.sv
// gpio_bank: N-pin GPIO peripheral with per-pin output enable, input
// synchroniser, set/clear output aliases and edge-triggered sticky interrupts.
// Bus: sel held until ack; one access per two cycles; read data registered.
module gpio_bank #(
  parameter int               N       = 8,
  parameter int               SYNC    = 2,
  parameter logic [N-1:0]     OUT_RST = {N{1'b0}},
  parameter logic [N-1:0]     OE_RST  = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         sel,
  input  logic         we,
  input  logic [2:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         ack,
  output logic         irq,
  inout  wire  [N-1:0] gpio_io
);

  logic [N-1:0] out_r;
  logic [N-1:0] oe_r;
  logic [N-1:0] rise_en_r;
  logic [N-1:0] fall_en_r;
  logic [N-1:0] pend_r;
  logic [N-1:0] prev_r;
  logic [N-1:0] sync_r [SYNC];
  logic         ack_r;
  logic         irq_r;
  logic [31:0]  rdata_r;

  logic [N-1:0] in_s;
  logic [N-1:0] rise_s;
  logic [N-1:0] fall_s;
  logic [N-1:0] edge_s;
  logic [N-1:0] wd_s;
  logic [N-1:0] pend_nxt_s;
  logic [31:0]  rd_s;
  logic         access_s;
  logic         unused_s;

  // Upper write-data bits beyond the pin count carry no meaning.
  assign unused_s = ^wdata;

  // Each pin is driven from OUT only while its enable is set.
  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    assign gpio_io[gi] = oe_r[gi] ? out_r[gi] : 1'bz;
  end

  // Edge detection, handshake qualifier and next pending state.
  always_comb begin
    in_s     = sync_r[SYNC-1];
    wd_s     = wdata[N-1:0];
    rise_s   = in_s & ~prev_r;
    fall_s   = ~in_s & prev_r;
    edge_s   = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    access_s = sel & ~ack_r;
    // A new edge wins over a simultaneous write-one-to-clear.
    if (access_s && we && (addr == 3'd5)) begin
      pend_nxt_s = (pend_r & ~wd_s) | edge_s;
    end else begin
      pend_nxt_s = pend_r | edge_s;
    end
  end

  // Read multiplexer; write-only aliases read as zero.
  always_comb begin
    rd_s = 32'd0;
    case (addr)
      3'd0:    rd_s[N-1:0] = out_r;
      3'd1:    rd_s[N-1:0] = oe_r;
      3'd2:    rd_s[N-1:0] = in_s;
      3'd3:    rd_s[N-1:0] = rise_en_r;
      3'd4:    rd_s[N-1:0] = fall_en_r;
      3'd5:    rd_s[N-1:0] = pend_r;
      default: rd_s = 32'd0;
    endcase
  end

  // Input synchroniser chain plus the one-cycle history used for edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC; i++) begin
        sync_r[i] <= {N{1'b0}};
      end
      prev_r <= {N{1'b0}};
    end else begin
      sync_r[0] <= gpio_io;
      for (int i = 1; i < SYNC; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= in_s;
    end
  end

  // Control registers, sticky pending bits and interrupt output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_r     <= OUT_RST;
      oe_r      <= OE_RST;
      rise_en_r <= {N{1'b0}};
      fall_en_r <= {N{1'b0}};
      pend_r    <= {N{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      irq_r  <= |(pend_r & (rise_en_r | fall_en_r));
      if (access_s && we) begin
        case (addr)
          3'd0:    out_r     <= wd_s;
          3'd1:    oe_r      <= wd_s;
          3'd3:    rise_en_r <= wd_s;
          3'd4:    fall_en_r <= wd_s;
          3'd6:    out_r     <= out_r | wd_s;
          3'd7:    out_r     <= out_r & ~wd_s;
          default: ;
        endcase
      end
    end
  end

  // Bus completion strobe and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r <= access_s;
      if (access_s && !we) begin
        rdata_r <= rd_s;
      end else begin
        rdata_r <= 32'd0;
      end
    end
  end

  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign irq   = irq_r;

endmodule
